// File: rtl/chanel_pkg.sv
// Shared types for the channel result buffer: result word pair and drain FSM states.
package chanel_pkg;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic        [DATA_W-1:0] ac;
    logic signed [DATA_W-1:0] ph;
  } chan_res_t;

  typedef enum logic {IDLE, PRESENT} rb_state_t;
endpackage

// File: rtl/chanel_result_buffer_if.sv
// Result strobe from the distributor plus the valid/ready drain toward the host.
interface chanel_result_buffer_if #(
  parameter int AW = 2,
  parameter int DW = 32
);
  logic          i_vld;
  logic [AW-1:0] i_addres;
  logic [DW-1:0] i_ac;
  logic [DW-1:0] i_ph;
  logic          o_vld;
  logic          o_ready;
  logic [AW-1:0] o_addres;
  logic [DW-1:0] o_ac;
  logic [DW-1:0] o_ph;
  logic          o_ovr;

  // producer/consumer side
  modport master (
    output i_vld, i_addres, i_ac, i_ph, o_ready,
    input  o_vld, o_addres, o_ac, o_ph, o_ovr
  );

  // buffer side
  modport slave (
    input  i_vld, i_addres, i_ac, i_ph, o_ready,
    output o_vld, o_addres, o_ac, o_ph, o_ovr
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, cyclically.
module rr_pick #(
  parameter  int N  = 4,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [AW-1:0] i_ptr,
  output logic [AW-1:0] o_gnt,
  output logic          o_any
);
  assign o_any = |i_req;

  // scan from the farthest offset down so the nearest request is the last one written
  always_comb begin
    logic [AW-1:0] w_idx;
    o_gnt = '0;
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = AW'((int'(i_ptr) + i) % N);
      if (i_req[w_idx]) o_gnt = w_idx;
    end
  end
endmodule

// File: rtl/chanel_result_buffer.sv
// One-entry-per-channel result store drained round-robin over valid/ready,
// with overrun flagging for results replaced before they were read.
module chanel_result_buffer
  import chanel_pkg::*;
#(
  parameter  int CHANELS = 4,
  parameter  int CNT_W   = 16,
  localparam int AW      = (CHANELS > 1) ? $clog2(CHANELS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  chanel_result_buffer_if.slave io_rb,
  output logic [CHANELS-1:0]   o_pending,
  output logic [CNT_W-1:0]     o_ovr_cnt
);
  chan_res_t          r_mem [CHANELS];
  logic [CHANELS-1:0] r_pend;
  logic [CHANELS-1:0] r_ovr;
  logic [AW-1:0]      r_rr_ptr;
  rb_state_t          r_state;
  logic               r_vld;
  logic [AW-1:0]      r_addres;
  chan_res_t          r_out;
  logic               r_out_ovr;
  logic [CNT_W-1:0]   r_ovr_cnt;

  logic               w_any;
  logic [AW-1:0]      w_sel;
  logic [AW-1:0]      w_ptr_nxt;
  logic               w_addr_ok;
  logic               w_wr;
  logic               w_load;
  logic               w_ovr_evt;
  logic [CHANELS-1:0] w_wr_oh;
  logic [CHANELS-1:0] w_clr_oh;
  logic [CHANELS-1:0] w_ovr_set;

  rr_pick #(.N(CHANELS)) u_pick (
    .i_req (r_pend),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_sel),
    .o_any (w_any)
  );

  // out-of-range channel indices can only occur when CHANELS is not a power of two
  generate
    if (CHANELS == (1 << AW)) begin : g_full
      assign w_addr_ok = 1'b1;
    end else begin : g_part
      assign w_addr_ok = (int'(io_rb.i_addres) < CHANELS);
    end
  endgenerate

  assign w_wr      = io_rb.i_vld & w_addr_ok;
  // load when idle, or when the presented entry is taken this cycle (o_vld is 1 in PRESENT)
  assign w_load    = w_any & ((r_state == IDLE) | io_rb.o_ready);
  assign w_ptr_nxt = (w_sel == AW'(CHANELS - 1)) ? '0 : w_sel + AW'(1);

  // one-hot write and consume decode
  always_comb begin
    w_wr_oh  = '0;
    w_clr_oh = '0;
    for (int c = 0; c < CHANELS; c++) begin
      w_wr_oh[c]  = w_wr   && (io_rb.i_addres == AW'(c));
      w_clr_oh[c] = w_load && (w_sel == AW'(c));
    end
  end

  // a slot consumed in the same cycle it is rewritten is not an overrun
  assign w_ovr_set = w_wr_oh & r_pend & ~w_clr_oh;
  assign w_ovr_evt = |w_ovr_set;

  // slot storage and pend/ovr flags; the write wins pend over a same-cycle consume
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < CHANELS; c++) r_mem[c] <= '0;
      r_pend <= '0;
      r_ovr  <= '0;
    end else begin
      for (int c = 0; c < CHANELS; c++) begin
        if (w_wr_oh[c]) begin
          r_mem[c].ac <= io_rb.i_ac;
          r_mem[c].ph <= io_rb.i_ph;
        end
      end
      r_pend <= w_wr_oh | (r_pend & ~w_clr_oh);
      r_ovr  <= w_ovr_set | (r_ovr & ~w_clr_oh);
    end
  end

  // saturating overrun counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovr_cnt <= '0;
    end else if (w_ovr_evt && (r_ovr_cnt != '1)) begin
      r_ovr_cnt <= r_ovr_cnt + CNT_W'(1);
    end
  end

  // drain FSM with registered presentation; loads read the pre-edge slot contents
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_vld     <= 1'b0;
      r_addres  <= '0;
      r_out     <= '0;
      r_out_ovr <= 1'b0;
      r_rr_ptr  <= '0;
    end else begin
      case (r_state)
        IDLE, PRESENT: begin
          if (w_load) begin
            r_state   <= PRESENT;
            r_vld     <= 1'b1;
            r_addres  <= w_sel;
            r_out     <= r_mem[w_sel];
            r_out_ovr <= r_ovr[w_sel];
            r_rr_ptr  <= w_ptr_nxt;
          end else if ((r_state == PRESENT) && io_rb.o_ready) begin
            r_state <= IDLE;
            r_vld   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  assign io_rb.o_vld    = r_vld;
  assign io_rb.o_addres = r_addres;
  assign io_rb.o_ac     = r_out.ac;
  assign io_rb.o_ph     = r_out.ph;
  assign io_rb.o_ovr    = r_out_ovr;
  assign o_pending      = r_pend;
  assign o_ovr_cnt      = r_ovr_cnt;
endmodule
